// File: rtl/tank_bullet.sv
// Single-bullet projectile for one tank: spawn at the muzzle, fly in the latched direction, retire on exit or hit, then cool down.
// Optional macro BULLET_AUTOFIRE_EN: a held fire key re-fires after each cooldown instead of needing a fresh press.
module tank_bullet #(
   parameter int          BULLET_STEP     = 4,
   parameter int          BULLET_SIZE     = 2,
   parameter int          COOLDOWN_FRAMES = 30,
   parameter int          X_MIN           = 1,
   parameter int          X_MAX           = 639,
   parameter int          Y_MIN           = 1,
   parameter int          Y_MAX           = 479,
   parameter logic [7:0]  FIRE_KEY        = 8'h2C
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [7:0]  keycode,
   input  logic [9:0]  TankX,
   input  logic [9:0]  TankY,
   input  logic [9:0]  TankS,
   input  logic [1:0]  direction,
   input  logic        hit,
   output logic [9:0]  BulletX,
   output logic [9:0]  BulletY,
   output logic [9:0]  BulletS,
   output logic        bullet_active,
   output logic        fire_ready
);

   localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
   localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);

   localparam logic [1:0] DIR_LEFT  = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_UP    = 2'b11;

   // Spawn window, signed so a muzzle past the left/top edge compares as negative.
   localparam logic signed [10:0] BSIZE_S    = 11'(BULLET_SIZE);
   localparam logic signed [10:0] SPAWN_X_LO = 11'(X_MIN + BULLET_SIZE);
   localparam logic signed [10:0] SPAWN_X_HI = 11'(X_MAX - BULLET_SIZE);
   localparam logic signed [10:0] SPAWN_Y_LO = 11'(Y_MIN + BULLET_SIZE);
   localparam logic signed [10:0] SPAWN_Y_HI = 11'(Y_MAX - BULLET_SIZE);

   localparam logic [10:0] EXIT_X_LO = 11'(X_MIN + BULLET_SIZE + BULLET_STEP);
   localparam logic [10:0] EXIT_Y_LO = 11'(Y_MIN + BULLET_SIZE + BULLET_STEP);
   localparam logic [10:0] EXIT_X_HI = 11'(X_MAX);
   localparam logic [10:0] EXIT_Y_HI = 11'(Y_MAX);
   localparam logic [10:0] LEAD      = 11'(BULLET_SIZE + BULLET_STEP);
   localparam logic [9:0]  STEP_V    = 10'(BULLET_STEP);

   typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} state_t;

   state_t            state_reg,    state_next;
   logic [9:0]        bullet_x_reg, bullet_x_next;
   logic [9:0]        bullet_y_reg, bullet_y_next;
   logic [1:0]        dir_reg,      dir_next;
   logic [CNT_W-1:0]  count_reg,    count_next;
   logic              fire_prev_reg;

   logic              fire_key_now;
   logic              fire_req;
   logic signed [10:0] tank_x_s, tank_y_s, offset_s;
   logic signed [10:0] spawn_x, spawn_y;
   logic              spawn_ok;
   logic [10:0]       bx_w, by_w;
   logic              exit_now;

   assign fire_key_now = (keycode == FIRE_KEY);

`ifdef BULLET_AUTOFIRE_EN
   assign fire_req = fire_key_now;
`else
   assign fire_req = fire_key_now && !fire_prev_reg;
`endif

   assign tank_x_s = $signed({1'b0, TankX});
   assign tank_y_s = $signed({1'b0, TankY});
   assign offset_s = $signed({1'b0, TankS}) + BSIZE_S;

   always_comb begin
      spawn_x = tank_x_s;
      spawn_y = tank_y_s;
      case (direction)
         DIR_LEFT:  spawn_x = tank_x_s - offset_s;
         DIR_RIGHT: spawn_x = tank_x_s + offset_s;
         DIR_DOWN:  spawn_y = tank_y_s + offset_s;
         default:   spawn_y = tank_y_s - offset_s;
      endcase
   end

   assign spawn_ok = (spawn_x >= SPAWN_X_LO) && (spawn_x <= SPAWN_X_HI) &&
                     (spawn_y >= SPAWN_Y_LO) && (spawn_y <= SPAWN_Y_HI);

   // Retire when the coming step would carry the bullet's edge past the playfield.
   assign bx_w = {1'b0, bullet_x_reg};
   assign by_w = {1'b0, bullet_y_reg};

   always_comb begin
      exit_now = 1'b0;
      case (dir_reg)
         DIR_LEFT:  exit_now = (bx_w < EXIT_X_LO);
         DIR_RIGHT: exit_now = ((bx_w + LEAD) > EXIT_X_HI);
         DIR_DOWN:  exit_now = ((by_w + LEAD) > EXIT_Y_HI);
         default:   exit_now = (by_w < EXIT_Y_LO);
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      bullet_x_next = bullet_x_reg;
      bullet_y_next = bullet_y_reg;
      dir_next      = dir_reg;
      count_next    = count_reg;
      case (state_reg)
         IDLE: begin
            if (fire_req) begin
               dir_next = direction;
               if (spawn_ok) begin
                  bullet_x_next = spawn_x[9:0];
                  bullet_y_next = spawn_y[9:0];
                  state_next    = FLY;
               end else begin
                  count_next = COOL_LOAD;
                  state_next = COOLDOWN;
               end
            end
         end
         FLY: begin
            if (hit || exit_now) begin
               count_next = COOL_LOAD;
               state_next = COOLDOWN;
            end else begin
               case (dir_reg)
                  DIR_LEFT:  bullet_x_next = bullet_x_reg - STEP_V;
                  DIR_RIGHT: bullet_x_next = bullet_x_reg + STEP_V;
                  DIR_DOWN:  bullet_y_next = bullet_y_reg + STEP_V;
                  default:   bullet_y_next = bullet_y_reg - STEP_V;
               endcase
            end
         end
         COOLDOWN: begin
            if (count_reg == '0)
               state_next = IDLE;
            else
               count_next = count_reg - 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= IDLE;
         bullet_x_reg  <= '0;
         bullet_y_reg  <= '0;
         dir_reg       <= DIR_LEFT;
         count_reg     <= '0;
         fire_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bullet_x_reg  <= bullet_x_next;
         bullet_y_reg  <= bullet_y_next;
         dir_reg       <= dir_next;
         count_reg     <= count_next;
         fire_prev_reg <= fire_key_now;
      end
   end

   assign BulletX       = bullet_x_reg;
   assign BulletY       = bullet_y_reg;
   assign BulletS       = 10'(BULLET_SIZE);
   assign bullet_active = (state_reg == FLY);
   assign fire_ready    = (state_reg == IDLE);

endmodule

// File: tb/tb_tank_bullet.sv
// Directed bench for tank_bullet: spawn/move, edge exit, hit, invalid spawn, held key, async reset mid-flight.
module tb_tank_bullet;

   logic        frame_clk;
   logic        Reset;
   logic [7:0]  keycode;
   logic [9:0]  TankX, TankY, TankS;
   logic [1:0]  direction;
   logic        hit;
   logic [9:0]  BulletX, BulletY, BulletS;
   logic        bullet_active, fire_ready;

   int checks   = 0;
   int failures = 0;
   int spawns;
   logic prev_active;

   tank_bullet dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .keycode       (keycode),
      .TankX         (TankX),
      .TankY         (TankY),
      .TankS         (TankS),
      .direction     (direction),
      .hit           (hit),
      .BulletX       (BulletX),
      .BulletY       (BulletY),
      .BulletS       (BulletS),
      .bullet_active (bullet_active),
      .fire_ready    (fire_ready)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1; keycode = 8'h00; hit = 1'b0;
      TankX = 10'd0; TankY = 10'd0; TankS = 10'd8; direction = 2'b00;
      step(); step();
      check("rst_x", BulletX, 0);
      check("rst_y", BulletY, 0);
      check("rst_active", bullet_active, 0);
      check("rst_ready", fire_ready, 1);
      check("bullet_s", BulletS, 2);
      Reset = 1'b0;
      step();
      check("idle_hold_ready", fire_ready, 1);

      // Spawn facing right, then steps of 4; tank motion after spawn is ignored.
      TankX = 10'd160; TankY = 10'd240; TankS = 10'd8; direction = 2'b01;
      keycode = 8'h2C;
      step();
      check("spawn_x", BulletX, 170);
      check("spawn_y", BulletY, 240);
      check("spawn_active", bullet_active, 1);
      check("spawn_ready", fire_ready, 0);
      keycode = 8'h00;
      step();
      check("move1_x", BulletX, 174);
      TankX = 10'd300; direction = 2'b00;
      step();
      check("move2_x", BulletX, 178);
      check("move2_y", BulletY, 240);
      repeat (114) step();
      check("last_x", BulletX, 634);
      check("last_active", bullet_active, 1);
      step();
      check("exit_active", bullet_active, 0);
      check("exit_x_frozen", BulletX, 634);
      check("exit_ready", fire_ready, 0);
      repeat (29) step();
      check("cool29_ready", fire_ready, 0);
      step();
      check("cool30_ready", fire_ready, 1);

      // Downward shot retired by a hit on its third flying edge.
      TankX = 10'd100; TankY = 10'd100; direction = 2'b10;
      keycode = 8'h2C;
      step();
      check("down_spawn_x", BulletX, 100);
      check("down_spawn_y", BulletY, 110);
      keycode = 8'h00;
      step();
      step();
      check("down_move_y", BulletY, 118);
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("hit_active", bullet_active, 0);
      check("hit_y_frozen", BulletY, 118);
      check("hit_x_frozen", BulletX, 100);
      keycode = 8'h2C;
      step();
      keycode = 8'h00;
      check("cool_fire_ignored", bullet_active, 0);
      repeat (28) step();
      check("hit_cool29_ready", fire_ready, 0);
      check("hit_cool29_active", bullet_active, 0);
      step();
      check("hit_cool30_ready", fire_ready, 1);

      // Muzzle at x=-1 is rejected straight into cooldown.
      TankX = 10'd9; TankY = 10'd240; direction = 2'b00;
      keycode = 8'h2C;
      step();
      keycode = 8'h00;
      check("inv_active", bullet_active, 0);
      check("inv_ready", fire_ready, 0);
      check("inv_x_held", BulletX, 100);
      check("inv_y_held", BulletY, 118);
      repeat (29) step();
      check("inv_cool29_ready", fire_ready, 0);
      step();
      check("inv_cool30_ready", fire_ready, 1);

      // Key held 200 frames firing up: flight 57 edges + 30 cooldown, so autofire lands 3 bullets.
      TankX = 10'd320; TankY = 10'd240; direction = 2'b11;
      keycode = 8'h2C;
      spawns = 0;
      prev_active = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (i == 0) check("held_spawn_y", BulletY, 230);
         if (bullet_active && !prev_active) spawns++;
         prev_active = bullet_active;
      end
`ifdef BULLET_AUTOFIRE_EN
      check("held_spawns", spawns, 3);
      check("held_end_active", bullet_active, 1);
`else
      check("held_spawns", spawns, 1);
      check("held_end_active", bullet_active, 0);
      check("held_end_ready", fire_ready, 1);
`endif
      keycode = 8'h00;
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      step();

      // Async reset in the middle of a flight.
      TankX = 10'd160; TankY = 10'd240; direction = 2'b01;
      keycode = 8'h2C;
      step();
      check("pre_rst_spawn_x", BulletX, 170);
      keycode = 8'h00;
      step();
      check("pre_rst_move_x", BulletX, 174);
      #3;
      Reset = 1'b1;
      #1;
      check("mid_rst_x", BulletX, 0);
      check("mid_rst_y", BulletY, 0);
      check("mid_rst_active", bullet_active, 0);
      check("mid_rst_ready", fire_ready, 1);
      #1;
      Reset = 1'b0;
      step();
      check("post_rst_idle", fire_ready, 1);
      keycode = 8'h2C;
      step();
      keycode = 8'h00;
      check("post_rst_spawn_x", BulletX, 170);
      check("post_rst_spawn_y", BulletY, 240);
      check("post_rst_active", bullet_active, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
